// File: rtl/rv32_bus_pkg.sv
// Shared definitions for the RV32 unified memory bus.
// State encoding and default watchdog depth.
package rv32_bus_pkg;

    typedef logic [1:0] bus_state_t;

    localparam bus_state_t IDLE    = 2'd0;
    localparam bus_state_t BUSY_IF = 2'd1;
    localparam bus_state_t BUSY_D  = 2'd2;

    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Per-transaction watchdog: clear/enable counter that saturates
// at TIMEOUT-1 and flags expiry there.
module bus_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between fetch and
// load/store, with registered bus outputs and a watchdog abort.
module mem_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic [XLEN-1:0] if_rdata_o,
    output logic            if_ack_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic [XLEN-1:0] d_wdata_i,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            d_ack_o,
    output logic            err_o,
    output logic            m_req_o,
    output logic            m_we_o,
    output logic [XLEN-1:0] m_addr_o,
    output logic [XLEN-1:0] m_wdata_o,
    input  logic [XLEN-1:0] m_rdata_i,
    input  logic            m_ack_i
);

    bus_state_t state;
    bus_state_t state_nxt;
    logic       last_d;
    logic       idle;
    logic       busy;
    logic       grant_if;
    logic       grant_d;
    logic       expired;
    logic       done;

    assign idle = (state == IDLE);
    assign busy = (state == BUSY_IF) || (state == BUSY_D);

    // On conflict, the port not served last wins.
    assign grant_d  = idle && d_req_i && (!if_req_i || !last_d);
    assign grant_if = idle && if_req_i && (!d_req_i || last_d);

    assign done = busy && (m_ack_i || expired);

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .clr     (grant_if || grant_d),
        .en      (busy && !m_ack_i),
        .expired (expired)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = BUSY_D;
                end else if (grant_if) begin
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_d    <= 1'b0;
            m_req_o   <= 1'b0;
            m_we_o    <= 1'b0;
            m_addr_o  <= '0;
            m_wdata_o <= '0;
        end else if (grant_d) begin
            last_d    <= 1'b1;
            m_req_o   <= 1'b1;
            m_we_o    <= d_we_i;
            m_addr_o  <= d_addr_i;
            m_wdata_o <= d_wdata_i;
        end else if (grant_if) begin
            last_d    <= 1'b0;
            m_req_o   <= 1'b1;
            m_we_o    <= 1'b0;
            m_addr_o  <= if_addr_i;
            m_wdata_o <= '0;
        end else if (done) begin
            m_req_o   <= 1'b0;
        end
    end

    // Ack goes straight back to the owner; a real ack beats expiry.
    always_comb begin
        if_ack_o   = 1'b0;
        d_ack_o    = 1'b0;
        err_o      = 1'b0;
        if_rdata_o = '0;
        d_rdata_o  = '0;
        unique case (state)
            BUSY_IF: begin
                if_ack_o = done;
                err_o    = expired && !m_ack_i;
                if (m_ack_i) begin
                    if_rdata_o = m_rdata_i;
                end
            end
            BUSY_D: begin
                d_ack_o = done;
                err_o   = expired && !m_ack_i;
                if (m_ack_i) begin
                    d_rdata_o = m_rdata_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario,
// inline comparisons against hand-computed values.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        err_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [31:0] m_rdata_i;
    logic        m_ack_i;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .XLEN    (32),
        .TIMEOUT (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_rdata_o (if_rdata_o),
        .if_ack_o   (if_ack_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_rdata_o  (d_rdata_o),
        .d_ack_o    (d_ack_o),
        .err_o      (err_o),
        .m_req_o    (m_req_o),
        .m_we_o     (m_we_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_rdata_i  (m_rdata_i),
        .m_ack_i    (m_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i     = 1'b0;
        if_req_i  = 1'b0;
        if_addr_i = '0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = '0;
        d_wdata_i = '0;
        m_rdata_i = '0;
        m_ack_i   = 1'b0;
        step();
        step();
        checks++;
        if ({m_req_o, m_we_o, m_addr_o, m_wdata_o} !== 66'd0) begin
            errors++;
            $display("FAIL reset_m got %b/%b/%h/%h exp 0",
                     m_req_o, m_we_o, m_addr_o, m_wdata_o);
        end
        checks++;
        if ({if_ack_o, d_ack_o, err_o, if_rdata_o, d_rdata_o} !== 67'd0) begin
            errors++;
            $display("FAIL reset_ack got %b/%b/%b/%h/%h exp 0",
                     if_ack_o, d_ack_o, err_o, if_rdata_o, d_rdata_o);
        end
        #2 rst_i = 1'b1;
        step();
        checks++;
        if (m_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release m_req got %b exp 0", m_req_o);
        end
    endtask

    task automatic test_fetch_read();
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        step();
        checks++;
        if ({m_req_o, m_we_o, m_addr_o} !== {1'b1, 1'b0, 32'h100}) begin
            errors++;
            $display("FAIL fetch_grant got %b/%b/%h exp 1/0/00000100",
                     m_req_o, m_we_o, m_addr_o);
        end
        checks++;
        if (if_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait1 ack got %b exp 0", if_ack_o);
        end
        step();
        checks++;
        if (if_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait2 ack got %b exp 0", if_ack_o);
        end
        step();
        m_ack_i   = 1'b1;
        m_rdata_i = 32'hDEADBEEF;
        if_req_i  = 1'b0;
        #1;
        checks++;
        if ({if_ack_o, if_rdata_o} !== {1'b1, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL fetch_ack got %b/%h exp 1/deadbeef",
                     if_ack_o, if_rdata_o);
        end
        checks++;
        if ({d_ack_o, d_rdata_o, err_o} !== 34'd0) begin
            errors++;
            $display("FAIL fetch_d_quiet got %b/%h/%b exp 0",
                     d_ack_o, d_rdata_o, err_o);
        end
        step();
        m_ack_i = 1'b0;
        #1;
        checks++;
        if ({if_ack_o, m_req_o, if_rdata_o} !== 34'd0) begin
            errors++;
            $display("FAIL fetch_after got %b/%b/%h exp 0",
                     if_ack_o, m_req_o, if_rdata_o);
        end
    endtask

    task automatic test_conflict();
        if_req_i  = 1'b1;
        if_addr_i = 32'h0;
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h200;
        d_wdata_i = 32'h55;
        step();
        checks++;
        if ({m_req_o, m_we_o, m_addr_o, m_wdata_o}
            !== {1'b1, 1'b1, 32'h200, 32'h55}) begin
            errors++;
            $display("FAIL conflict_d_first got %b/%b/%h/%h exp 1/1/200/55",
                     m_req_o, m_we_o, m_addr_o, m_wdata_o);
        end
        // data acked with zero wait; data re-requests immediately
        m_ack_i   = 1'b1;
        d_addr_i  = 32'h204;
        d_wdata_i = 32'h66;
        #1;
        checks++;
        if ({d_ack_o, if_ack_o, m_addr_o} !== {1'b1, 1'b0, 32'h200}) begin
            errors++;
            $display("FAIL conflict_d_ack got %b/%b/%h exp 1/0/200",
                     d_ack_o, if_ack_o, m_addr_o);
        end
        step();
        m_ack_i = 1'b0;
        step();
        checks++;
        if ({m_req_o, m_we_o, m_addr_o, m_wdata_o}
            !== {1'b1, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL conflict_if_second got %b/%b/%h/%h exp 1/0/0/0",
                     m_req_o, m_we_o, m_addr_o, m_wdata_o);
        end
        m_ack_i  = 1'b1;
        if_req_i = 1'b0;
        #1;
        checks++;
        if ({if_ack_o, d_ack_o} !== 2'b10) begin
            errors++;
            $display("FAIL conflict_if_ack got %b/%b exp 1/0",
                     if_ack_o, d_ack_o);
        end
        step();
        m_ack_i = 1'b0;
        step();
        checks++;
        if ({m_req_o, m_we_o, m_addr_o, m_wdata_o}
            !== {1'b1, 1'b1, 32'h204, 32'h66}) begin
            errors++;
            $display("FAIL conflict_d_third got %b/%b/%h/%h exp 1/1/204/66",
                     m_req_o, m_we_o, m_addr_o, m_wdata_o);
        end
        m_ack_i = 1'b1;
        d_req_i = 1'b0;
        step();
        m_ack_i = 1'b0;
        // data was served last, so fetch wins this conflict
        if_req_i  = 1'b1;
        if_addr_i = 32'h40;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h208;
        step();
        checks++;
        if ({m_req_o, m_we_o, m_addr_o} !== {1'b1, 1'b0, 32'h40}) begin
            errors++;
            $display("FAIL conflict_rr got %b/%b/%h exp 1/0/40",
                     m_req_o, m_we_o, m_addr_o);
        end
        m_ack_i  = 1'b1;
        if_req_i = 1'b0;
        step();
        m_ack_i = 1'b0;
        step();
        checks++;
        if ({m_req_o, m_we_o, m_addr_o} !== {1'b1, 1'b0, 32'h208}) begin
            errors++;
            $display("FAIL conflict_rr_d got %b/%b/%h exp 1/0/208",
                     m_req_o, m_we_o, m_addr_o);
        end
        m_ack_i = 1'b1;
        d_req_i = 1'b0;
        step();
        m_ack_i = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h300;
        m_rdata_i = 32'hFFFFFFFF;
        step();
        checks++;
        if ({m_req_o, m_addr_o} !== {1'b1, 32'h300}) begin
            errors++;
            $display("FAIL timeout_grant got %b/%h exp 1/300",
                     m_req_o, m_addr_o);
        end
        for (int c = 1; c < 16; c++) begin
            checks++;
            if ({d_ack_o, err_o, m_req_o} !== 3'b001) begin
                errors++;
                $display("FAIL timeout_wait%0d got %b/%b/%b exp 0/0/1",
                         c, d_ack_o, err_o, m_req_o);
            end
            step();
        end
        d_req_i = 1'b0;
        #1;
        checks++;
        if ({d_ack_o, err_o, d_rdata_o} !== {1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL timeout_abort got %b/%b/%h exp 1/1/0",
                     d_ack_o, err_o, d_rdata_o);
        end
        step();
        checks++;
        if ({m_req_o, d_ack_o, err_o} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_after got %b/%b/%b exp 0",
                     m_req_o, d_ack_o, err_o);
        end
    endtask

    task automatic test_ack_at_timeout();
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h304;
        step();
        for (int c = 1; c < 16; c++) begin
            step();
        end
        m_ack_i   = 1'b1;
        m_rdata_i = 32'h1234;
        d_req_i   = 1'b0;
        #1;
        checks++;
        if ({d_ack_o, err_o, d_rdata_o} !== {1'b1, 1'b0, 32'h1234}) begin
            errors++;
            $display("FAIL ack_at_to got %b/%b/%h exp 1/0/1234",
                     d_ack_o, err_o, d_rdata_o);
        end
        step();
        m_ack_i = 1'b0;
        #1;
        checks++;
        if ({m_req_o, d_ack_o} !== 2'b00) begin
            errors++;
            $display("FAIL ack_at_to_after got %b/%b exp 0/0",
                     m_req_o, d_ack_o);
        end
    endtask

    task automatic test_req_drop();
        if_req_i  = 1'b1;
        if_addr_i = 32'h500;
        step();
        if_req_i = 1'b0;
        step();
        checks++;
        if ({m_req_o, m_addr_o, if_ack_o} !== {1'b1, 32'h500, 1'b0}) begin
            errors++;
            $display("FAIL drop_hold got %b/%h/%b exp 1/500/0",
                     m_req_o, m_addr_o, if_ack_o);
        end
        step();
        m_ack_i   = 1'b1;
        m_rdata_i = 32'hCAFEF00D;
        #1;
        checks++;
        if ({if_ack_o, if_rdata_o} !== {1'b1, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL drop_ack got %b/%h exp 1/cafef00d",
                     if_ack_o, if_rdata_o);
        end
        step();
        m_ack_i = 1'b0;
        #1;
        checks++;
        if ({m_req_o, if_ack_o} !== 2'b00) begin
            errors++;
            $display("FAIL drop_after got %b/%b exp 0/0",
                     m_req_o, if_ack_o);
        end
    endtask

    task automatic test_back_to_back();
        if_req_i  = 1'b1;
        if_addr_i = 32'h600;
        step();
        m_ack_i   = 1'b1;
        m_rdata_i = 32'hA5A5A5A5;
        #1;
        checks++;
        if ({m_req_o, if_ack_o} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_first got %b/%b exp 1/1", m_req_o, if_ack_o);
        end
        if_addr_i = 32'h604;
        step();
        m_ack_i = 1'b0;
        #1;
        checks++;
        if ({m_req_o, if_ack_o} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_gap got %b/%b exp 0/0", m_req_o, if_ack_o);
        end
        step();
        checks++;
        if ({m_req_o, m_addr_o} !== {1'b1, 32'h604}) begin
            errors++;
            $display("FAIL b2b_second got %b/%h exp 1/604",
                     m_req_o, m_addr_o);
        end
        m_ack_i  = 1'b1;
        if_req_i = 1'b0;
        step();
        m_ack_i = 1'b0;
        #1;
    endtask

    task automatic test_idle_ack();
        m_ack_i   = 1'b1;
        m_rdata_i = 32'h77777777;
        #1;
        checks++;
        if ({if_ack_o, d_ack_o, err_o, if_rdata_o, d_rdata_o} !== 67'd0) begin
            errors++;
            $display("FAIL idle_ack got %b/%b/%b/%h/%h exp 0",
                     if_ack_o, d_ack_o, err_o, if_rdata_o, d_rdata_o);
        end
        step();
        m_ack_i = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid_op();
        d_req_i  = 1'b1;
        d_we_i   = 1'b1;
        d_addr_i = 32'h700;
        step();
        checks++;
        if ({m_req_o, m_addr_o} !== {1'b1, 32'h700}) begin
            errors++;
            $display("FAIL rst_mid_grant got %b/%h exp 1/700",
                     m_req_o, m_addr_o);
        end
        rst_i     = 1'b0;
        m_ack_i   = 1'b1;
        if_req_i  = 1'b1;
        if_addr_i = 32'h800;
        #1;
        checks++;
        if ({m_req_o, d_ack_o, if_ack_o, err_o} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_drop got %b/%b/%b/%b exp 0",
                     m_req_o, d_ack_o, if_ack_o, err_o);
        end
        d_req_i = 1'b0;
        m_ack_i = 1'b0;
        #1 rst_i = 1'b1;
        step();
        checks++;
        if ({m_req_o, m_we_o, m_addr_o} !== {1'b1, 1'b0, 32'h800}) begin
            errors++;
            $display("FAIL rst_mid_regrant got %b/%b/%h exp 1/0/800",
                     m_req_o, m_we_o, m_addr_o);
        end
        m_ack_i  = 1'b1;
        if_req_i = 1'b0;
        step();
        m_ack_i = 1'b0;
        #1;
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_conflict();
        test_timeout();
        test_ack_at_timeout();
        test_req_drop();
        test_back_to_back();
        test_idle_ack();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
